// File: rtl/usb_line_pkg.sv
// Shared USB line definitions: line-state and receiver-state enums, SYNC pattern and
// the helpers used to classify a raw DP/DM sample.
package usb_line_pkg;

    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10,
        LINE_SE1 = 2'b11
    } line_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_SYNC,
        RX_DATA,
        RX_EOP,
        RX_ERR
    } rx_state_t;

    // Bit i set means sample i of SYNC is K (K J K J K J K K, first sample in bit 0)
    localparam logic [7:0] SYNC_K_MASK    = 8'b1101_0101;
    localparam int         MAX_STUFF_ONES = 6;
    localparam int         DEF_MAX_BYTES  = 67;
    localparam int         DEF_EOP_SE0    = 2;

    function automatic line_t decode_line(input logic dp, input logic dm);
        return line_t'({dp, dm});
    endfunction

    function automatic logic is_data_line(input line_t l);
        return (l == LINE_J) || (l == LINE_K);
    endfunction

endpackage

// File: rtl/usb_dev_rx_if.sv
// Line inputs and byte/framing outputs of the device receiver.
// pid_err exists only when USB_RX_PID_CHECK_EN is defined.
interface usb_dev_rx_if;
    logic       dp;
    logic       dm;
    logic       rx_en;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       pkt_start;
    logic       pkt_end;
    logic [6:0] byte_cnt;
    logic       active;
    logic       stuff_err;
    logic       align_err;
    logic       eop_err;
    logic       len_err;
`ifdef USB_RX_PID_CHECK_EN
    logic       pid_err;
`endif

    modport master (
`ifdef USB_RX_PID_CHECK_EN
        output pid_err,
`endif
        input  dp, dm, rx_en,
        output byte_data, byte_valid, pkt_start, pkt_end, byte_cnt, active,
        output stuff_err, align_err, eop_err, len_err
    );

    modport slave (
`ifdef USB_RX_PID_CHECK_EN
        input  pid_err,
`endif
        output dp, dm, rx_en,
        input  byte_data, byte_valid, pkt_start, pkt_end, byte_cnt, active,
        input  stuff_err, align_err, eop_err, len_err
    );
endinterface

// File: rtl/usb_nrzi_unstuff.sv
// Per-sample NRZI decode with stuff-bit removal; the running line reference and ones
// count restart from K/0 whenever clear is high.
module usb_nrzi_unstuff
    import usb_line_pkg::*;
(
    input  logic  clk,
    input  logic  rst_b,
    input  logic  clear,
    input  logic  enable,
    input  line_t line,
    output logic  rx_bit,
    output logic  bit_valid,
    output logic  stuff_err
);
    localparam logic [2:0] STUFF_LIMIT = 3'(MAX_STUFF_ONES);

    line_t      prev_line;
    logic [2:0] ones_cnt;
    logic       data_line;
    logic       stuff_due;

    assign data_line = is_data_line(line);
    assign stuff_due = (ones_cnt == STUFF_LIMIT);
    assign rx_bit    = data_line && (line == prev_line);
    assign bit_valid = enable && data_line && !stuff_due;
    // Anything but a decoded 0 where a stuff bit is owed is an error, SE0 included
    assign stuff_err = enable && stuff_due && !(data_line && !rx_bit);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            prev_line <= LINE_K;
            ones_cnt  <= 3'd0;
        end else if (clear) begin
            prev_line <= LINE_K;
            ones_cnt  <= 3'd0;
        end else if (enable && data_line) begin
            prev_line <= line;
            if (stuff_due || !rx_bit)
                ones_cnt <= 3'd0;
            else
                ones_cnt <= ones_cnt + 3'd1;
        end
    end
endmodule

// File: rtl/usb_dev_rx.sv
// Device-side USB receiver: SYNC detect, NRZI/unstuff, LSB-first byte assembly, EOP and
// error framing. Define USB_RX_PID_CHECK_EN to add the PID complement check and pid_err.
module usb_dev_rx
    import usb_line_pkg::*;
#(
    parameter int MAX_BYTES = DEF_MAX_BYTES,
    parameter int EOP_SE0   = DEF_EOP_SE0
) (
    input logic          clk,
    input logic          rst_b,
    usb_dev_rx_if.master bus
);
    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);
    localparam logic [3:0] SE0_CNT = 4'(EOP_SE0);

    rx_state_t  state;
    logic [2:0] sync_idx;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;
    logic [3:0] se0_cnt;
    logic       err_j;
    line_t      line;
    logic       sample_k;
    logic       sync_hit;
    logic       rx_bit;
    logic       bit_valid;
    logic       stuff_hit;
    logic       dec_clear;
    logic       dec_enable;
    logic [7:0] next_byte;

    assign line       = decode_line(bus.dp, bus.dm);
    assign sample_k   = (line == LINE_K);
    assign sync_hit   = (line == (SYNC_K_MASK[sync_idx] ? LINE_K : LINE_J));
    assign next_byte  = {rx_bit, shift_reg[7:1]};
    assign dec_clear  = !bus.rx_en || (state == RX_IDLE) || (state == RX_SYNC);
    assign dec_enable = bus.rx_en && (state == RX_DATA);

    usb_nrzi_unstuff u_dec (
        .clk       (clk),
        .rst_b     (rst_b),
        .clear     (dec_clear),
        .enable    (dec_enable),
        .line      (line),
        .rx_bit    (rx_bit),
        .bit_valid (bit_valid),
        .stuff_err (stuff_hit)
    );

    // Receiver FSM; every status output is registered here and strobes default low
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state          <= RX_IDLE;
            sync_idx       <= 3'd0;
            bit_idx        <= 3'd0;
            shift_reg      <= 8'd0;
            se0_cnt        <= 4'd0;
            err_j          <= 1'b0;
            bus.byte_data  <= 8'd0;
            bus.byte_valid <= 1'b0;
            bus.pkt_start  <= 1'b0;
            bus.pkt_end    <= 1'b0;
            bus.byte_cnt   <= 7'd0;
            bus.active     <= 1'b0;
            bus.stuff_err  <= 1'b0;
            bus.align_err  <= 1'b0;
            bus.eop_err    <= 1'b0;
            bus.len_err    <= 1'b0;
`ifdef USB_RX_PID_CHECK_EN
            bus.pid_err    <= 1'b0;
`endif
        end else begin
            bus.byte_valid <= 1'b0;
            bus.pkt_start  <= 1'b0;
            bus.pkt_end    <= 1'b0;
            bus.stuff_err  <= 1'b0;
            bus.align_err  <= 1'b0;
            bus.eop_err    <= 1'b0;
            bus.len_err    <= 1'b0;
`ifdef USB_RX_PID_CHECK_EN
            bus.pid_err    <= 1'b0;
`endif
            if (!bus.rx_en) begin
                state      <= RX_IDLE;
                sync_idx   <= 3'd0;
                bit_idx    <= 3'd0;
                se0_cnt    <= 4'd0;
                err_j      <= 1'b0;
                bus.active <= 1'b0;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (sample_k) begin
                            state    <= RX_SYNC;
                            sync_idx <= 3'd1;
                        end
                    end
                    RX_SYNC: begin
                        if (sync_hit) begin
                            if (sync_idx == 3'd7) begin
                                state         <= RX_DATA;
                                sync_idx      <= 3'd0;
                                bit_idx       <= 3'd0;
                                shift_reg     <= 8'd0;
                                bus.byte_cnt  <= 7'd0;
                                bus.pkt_start <= 1'b1;
                                bus.active    <= 1'b1;
                            end else begin
                                sync_idx <= sync_idx + 3'd1;
                            end
                        end else begin
                            // A stray K may itself be the first SYNC sample
                            sync_idx <= sample_k ? 3'd1 : 3'd0;
                            state    <= sample_k ? RX_SYNC : RX_IDLE;
                        end
                    end
                    RX_DATA: begin
                        if (stuff_hit) begin
                            bus.stuff_err <= 1'b1;
                            bus.active    <= 1'b0;
                            err_j         <= 1'b0;
                            state         <= RX_ERR;
                        end else if (line == LINE_SE0) begin
                            if (bit_idx != 3'd0) begin
                                bus.align_err <= 1'b1;
                                bus.active    <= 1'b0;
                                err_j         <= 1'b0;
                                state         <= RX_ERR;
                            end else begin
                                se0_cnt <= 4'd1;
                                state   <= RX_EOP;
                            end
                        end else if (line == LINE_SE1) begin
                            bus.eop_err <= 1'b1;
                            bus.active  <= 1'b0;
                            err_j       <= 1'b0;
                            state       <= RX_ERR;
                        end else if (bit_valid) begin
                            shift_reg <= next_byte;
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                if (bus.byte_cnt == MAX_CNT) begin
                                    bus.len_err <= 1'b1;
                                    bus.active  <= 1'b0;
                                    err_j       <= 1'b0;
                                    state       <= RX_ERR;
                                end else begin
                                    bus.byte_valid <= 1'b1;
                                    bus.byte_data  <= next_byte;
                                    bus.byte_cnt   <= bus.byte_cnt + 7'd1;
`ifdef USB_RX_PID_CHECK_EN
                                    if (bus.byte_cnt == 7'd0 && next_byte[7:4] != ~next_byte[3:0]) begin
                                        bus.pid_err <= 1'b1;
                                        bus.active  <= 1'b0;
                                        err_j       <= 1'b0;
                                        state       <= RX_ERR;
                                    end
`endif
                                end
                            end
                        end
                    end
                    RX_EOP: begin
                        if (line == LINE_SE0 && se0_cnt < SE0_CNT) begin
                            se0_cnt <= se0_cnt + 4'd1;
                        end else if (line == LINE_J && se0_cnt == SE0_CNT) begin
                            bus.pkt_end <= 1'b1;
                            bus.active  <= 1'b0;
                            se0_cnt     <= 4'd0;
                            state       <= RX_IDLE;
                        end else begin
                            bus.eop_err <= 1'b1;
                            bus.active  <= 1'b0;
                            se0_cnt     <= 4'd0;
                            err_j       <= 1'b0;
                            state       <= RX_ERR;
                        end
                    end
                    RX_ERR: begin
                        if (line == LINE_J) begin
                            err_j <= 1'b1;
                            if (err_j)
                                state <= RX_IDLE;
                        end else begin
                            err_j <= 1'b0;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_dev_rx.sv
// Bench for usb_dev_rx: packets are built from byte lists (LSB-first, stuffing, NRZI)
// and the delivered bytes and framing pulses are compared with what those lists imply.
module tb_usb_dev_rx;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    logic clk;
    logic rst_b;

    usb_dev_rx_if bus ();

    usb_dev_rx #(.MAX_BYTES(67), .EOP_SE0(2)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_checks = 0;
    int bad_checks   = 0;

    logic [2:0] line_q[$];
    logic [7:0] pkt_bytes[$];
    logic [7:0] exp_bytes[$];
    logic [1:0] level;
    int         ones_run;
    logic       stuff_fault;

    logic [7:0] obs_bytes[$];
    logic [6:0] obs_cnts[$];
    int start_seen, end_seen, stuff_seen, align_seen, eop_seen, len_seen, pid_seen, overlap_seen;
    int b_bytes, b_start, b_end, b_stuff, b_align, b_eop, b_len, b_pid, b_overlap;

    initial begin
        start_seen = 0; end_seen = 0; stuff_seen = 0; align_seen = 0;
        eop_seen = 0; len_seen = 0; pid_seen = 0; overlap_seen = 0;
    end

    // Passive monitor collecting strobes, sampled half a cycle away from the active edge
    always @(negedge clk) begin
        if (rst_b) begin
            if (bus.byte_valid) begin
                obs_bytes.push_back(bus.byte_data);
                obs_cnts.push_back(bus.byte_cnt);
            end
            if (bus.byte_valid && bus.pkt_end) overlap_seen++;
            if (bus.pkt_start) start_seen++;
            if (bus.pkt_end)   end_seen++;
            if (bus.stuff_err) stuff_seen++;
            if (bus.align_err) align_seen++;
            if (bus.eop_err)   eop_seen++;
            if (bus.len_err)   len_seen++;
`ifdef USB_RX_PID_CHECK_EN
            if (bus.pid_err)   pid_seen++;
`endif
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_checks++;
        if (got !== want) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] out_vec();
        logic [31:0] v;
        v = '0;
        v[21:0] = {bus.byte_data, bus.byte_cnt, bus.byte_valid, bus.pkt_start, bus.pkt_end,
                   bus.active, bus.stuff_err, bus.align_err, bus.eop_err, bus.len_err};
`ifdef USB_RX_PID_CHECK_EN
        v[22] = bus.pid_err;
`endif
        return v;
    endfunction

    task automatic add_raw(input logic en, input logic [1:0] l);
        line_q.push_back({en, l});
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add_raw(1'b1, LJ);
    endtask

    task automatic add_sync();
        for (int i = 0; i < 7; i++) add_raw(1'b1, (i % 2 == 0) ? LK : LJ);
        add_raw(1'b1, LK);
        level    = LK;
        ones_run = 0;
    endtask

    // NRZI: a 1 keeps the level, a 0 toggles it; a 0 is forced in after six 1s
    task automatic add_bit(input logic b);
        if (b) begin
            ones_run++;
        end else begin
            level    = ~level;
            ones_run = 0;
        end
        add_raw(1'b1, level);
        if (ones_run == 6) begin
            if (stuff_fault) stuff_fault = 1'b0;
            else level = ~level;
            add_raw(1'b1, level);
            ones_run = 0;
        end
    endtask

    task automatic add_byte(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) add_bit(b[i]);
    endtask

    task automatic add_eop(input int n_se0);
        for (int i = 0; i < n_se0; i++) add_raw(1'b1, LSE0);
        add_raw(1'b1, LJ);
    endtask

    task automatic add_packet();
        add_sync();
        foreach (pkt_bytes[i]) add_byte(pkt_bytes[i], 8);
        add_eop(2);
        add_idle(6);
    endtask

    task automatic applyStimulus();
        logic [2:0] v;
        while (line_q.size() > 0) begin
            v = line_q.pop_front();
            @(negedge clk);
            bus.rx_en = v[2];
            bus.dp    = v[1];
            bus.dm    = v[0];
        end
    endtask

    task automatic begin_case();
        b_bytes = obs_bytes.size();
        b_start = start_seen; b_end = end_seen; b_stuff = stuff_seen; b_align = align_seen;
        b_eop = eop_seen; b_len = len_seen; b_pid = pid_seen; b_overlap = overlap_seen;
    endtask

    task automatic end_case(input string tag, input int e_end, input int e_stuff, input int e_align,
                            input int e_eop, input int e_len, input int e_pid);
        checkOutput({tag, "_nbytes"}, obs_bytes.size() - b_bytes, exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++) begin
            if (b_bytes + i < obs_bytes.size()) begin
                checkOutput($sformatf("%s_byte%0d", tag, i), obs_bytes[b_bytes + i], exp_bytes[i]);
                checkOutput($sformatf("%s_cnt%0d", tag, i), obs_cnts[b_bytes + i], i + 1);
            end
        end
        checkOutput({tag, "_pkt_start"}, start_seen - b_start, 1);
        checkOutput({tag, "_pkt_end"},   end_seen - b_end, e_end);
        checkOutput({tag, "_stuff_err"}, stuff_seen - b_stuff, e_stuff);
        checkOutput({tag, "_align_err"}, align_seen - b_align, e_align);
        checkOutput({tag, "_eop_err"},   eop_seen - b_eop, e_eop);
        checkOutput({tag, "_len_err"},   len_seen - b_len, e_len);
        checkOutput({tag, "_pid_err"},   pid_seen - b_pid, e_pid);
        checkOutput({tag, "_overlap"},   overlap_seen - b_overlap, 0);
        checkOutput({tag, "_active"},    bus.active, 0);
        if (e_end == 1) checkOutput({tag, "_byte_cnt"}, bus.byte_cnt, exp_bytes.size());
    endtask

    task automatic clean_packet(input string tag);
        begin_case();
        exp_bytes = pkt_bytes;
        add_idle(2);
        add_packet();
        applyStimulus();
        end_case(tag, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [3:0] p;
        int         n;
        stuff_fault = 1'b0;
        level       = LJ;
        ones_run    = 0;
        rst_b       = 1'b0;
        bus.rx_en   = 1'b1;
        bus.dp      = 1'b1;
        bus.dm      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", out_vec(), 32'd0);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_reset", out_vec(), 32'd0);

        pkt_bytes = '{8'hD2};
        clean_packet("ack");

        pkt_bytes = '{8'hC3, 8'hFF, 8'h01};
        clean_packet("data0_stuffed");

        $display("[TB] inverted stuff bit");
        begin_case();
        pkt_bytes   = '{8'hC3, 8'hFF, 8'h01};
        exp_bytes   = '{8'hC3};
        stuff_fault = 1'b1;
        add_idle(2);
        add_packet();
        applyStimulus();
        end_case("stuff", 0, 1, 0, 0, 0, 0);
        pkt_bytes = '{8'hD2};
        clean_packet("after_stuff");

        begin_case();
        exp_bytes = '{8'hA5};
        add_idle(2); add_sync(); add_byte(8'hA5, 8); add_byte(8'h3C, 4); add_eop(2); add_idle(6);
        applyStimulus();
        end_case("align", 0, 0, 1, 0, 0, 0);

        begin_case();
        exp_bytes = '{8'hC3};
        add_idle(2); add_sync(); add_byte(8'hC3, 8); add_eop(3); add_idle(6);
        applyStimulus();
        end_case("long_eop", 0, 0, 0, 1, 0, 0);

        $display("[TB] corrupted SYNC then full SYNC");
        begin_case();
        pkt_bytes = '{8'h4B, 8'h17};
        exp_bytes = pkt_bytes;
        add_idle(2);
        foreach (pkt_bytes[i]) ;
        add_raw(1'b1, LK); add_raw(1'b1, LJ); add_raw(1'b1, LK); add_raw(1'b1, LK);
        add_raw(1'b1, LJ); add_raw(1'b1, LK); add_raw(1'b1, LJ); add_raw(1'b1, LK); add_raw(1'b1, LK);
        add_packet();
        applyStimulus();
        end_case("bad_sync", 1, 0, 0, 0, 0, 0);

        begin_case();
        pkt_bytes = '{8'hC3};
        for (int i = 0; i < 67; i++) pkt_bytes.push_back(8'($urandom));
        exp_bytes = pkt_bytes;
        void'(exp_bytes.pop_back());
        add_idle(2);
        add_packet();
        applyStimulus();
        end_case("too_long", 0, 0, 0, 0, 1, 0);

        begin_case();
        exp_bytes = '{8'hC3};
        add_idle(2); add_sync(); add_byte(8'hC3, 8); add_byte(8'h5A, 4);
        for (int i = 0; i < 4; i++) add_raw(1'b0, LJ);
        add_idle(6);
        applyStimulus();
        end_case("rx_en_drop", 0, 0, 0, 0, 0, 0);
        pkt_bytes = '{8'h69, 8'h80};
        clean_packet("after_rx_en");

        add_idle(2); add_sync(); add_byte(8'hC3, 8); add_byte(8'hFF, 3);
        applyStimulus();
        @(negedge clk);
        checkOutput("active_mid_pkt", bus.active, 1);
        rst_b = 1'b0;
        #1;
        checkOutput("reset_mid_pkt", out_vec(), 32'd0);
        bus.dp = 1'b1;
        bus.dm = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        pkt_bytes = '{8'hE1, 8'h00, 8'hFF};
        clean_packet("after_reset");

`ifdef USB_RX_PID_CHECK_EN
        begin_case();
        pkt_bytes = '{8'hD3, 8'h55};
        exp_bytes = '{8'hD3};
        add_idle(2);
        add_packet();
        applyStimulus();
        end_case("pid", 0, 0, 0, 0, 0, 1);
`endif

        $display("[TB] random packets");
        for (int r = 0; r < 15; r++) begin
            p = 4'($urandom_range(0, 15));
            n = int'($urandom_range(1, 12));
            pkt_bytes = '{{~p, p}};
            for (int i = 1; i < n; i++)
                pkt_bytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            clean_packet($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule

// File: doc/usb_dev_rx.md
Name: usb_dev_rx

Overview:
Device-side USB line receiver: the far end of the host's DP/DM writer. It samples DP/DM once per clk and detects SYNC. It NRZI-decodes, removes stuff bits, assembles bytes LSB-first and detects EOP. It delivers bytes with a valid strobe to the device protocol FSM, with packet start/end framing and error flags.

Parameters:
MAX_BYTES, 67, maximum bytes per packet (PID + 64 data + CRC16); exceeding it raises len_err
EOP_SE0, 2, required number of SE0 cycles in EOP before J

Ports:
clk  input  1  clock, one USB bit time per cycle
rst_b  input  1  reset, asynchronous, active-low
dp  input  1  D+ line sample
dm  input  1  D- line sample
rx_en  input  1  receive enable; low while device transmits
byte_data  output  8  assembled byte, LSB received first
byte_valid  output  1  one-cycle strobe, byte_data valid
pkt_start  output  1  one-cycle pulse, cycle after SYNC completes
pkt_end  output  1  one-cycle pulse on clean EOP completion
byte_cnt  output  7  bytes delivered in current packet
active  output  1  high from SYNC completion through EOP/error exit
stuff_err  output  1  one-cycle pulse: 7th consecutive decoded 1
align_err  output  1  one-cycle pulse: EOP at non-byte boundary
eop_err  output  1  one-cycle pulse: malformed EOP
len_err  output  1  one-cycle pulse: byte count exceeds MAX_BYTES

Behaviour:
- Line states: J = dp1/dm0, K = dp0/dm1, SE0 = 00, SE1 = 11 (always illegal outside IDLE).
- Reset: all outputs 0, byte_cnt 0, state IDLE, shift register 0, ones count 0.
- States: IDLE, SYNC, DATA, EOP, ERR.
- IDLE: matches raw pattern K J K J K J K K with a 3-bit index; a mismatch resets the index, or restarts it at 1 if the sample is K. The 8th matching sample moves to DATA. pkt_start and active go high the next cycle. The NRZI reference is set to K and the ones count to 0.
- DATA: a J/K equal to the previous line state decodes as 1; a change decodes as 0. The ones count increments on 1 and clears on 0.
- After six consecutive 1s, the next bit is a stuff bit. If it decodes 0, it is discarded and the count cleared. If it decodes 1, stuff_err pulses and the state goes to ERR.
- Non-stuff bits shift into an 8-bit register LSB-first; the 3-bit bit_idx wraps 7->0.
- On the 8th bit, byte_valid pulses the following cycle with byte_data and byte_cnt+1.
- If byte_cnt would exceed MAX_BYTES, len_err pulses instead of byte_valid and the state goes to ERR.
- DATA on SE0: if bit_idx != 0, align_err pulses and the state goes to ERR. Otherwise the state goes to EOP with se0_cnt = 1. SE1 in DATA goes to ERR with eop_err.
- EOP: SE0 increments se0_cnt. J with se0_cnt == EOP_SE0 pulses pkt_end, drops active and returns to IDLE.
- EOP, any other case pulses eop_err and goes to ERR: J with the wrong count, K, SE1, or se0_cnt exceeding EOP_SE0.
- ERR: active drops. The block waits for 2 consecutive J samples, then returns to IDLE. No byte_valid is issued.
- rx_en low: synchronously forces IDLE next cycle and clears counters. No strobes are produced while low, and a packet in flight is abandoned silently with no error pulse.
- Simultaneous events: the stuff-bit check has priority over SE0 detection in the same sample. byte_valid and pkt_end never coincide, because the EOP path adds at least 2 cycles.
- byte_data holds its last value between strobes. byte_cnt holds until the next pkt_start, then clears to 0.

Optional Feature:
USB_RX_PID_CHECK_EN:
- Defined: for the first byte of each packet, byte[7:4] must equal ~byte[3:0]. On mismatch, the byte is still delivered with byte_valid, then pid_err (extra 1-bit output) pulses the same cycle and the state goes to ERR.
- Undefined: pid_err is absent and no PID check is made.

Decomposition:
- Shared package usb_line_pkg: line-state enum {J, K, SE0, SE1} and its decode function; SYNC pattern constant 8'b... sequence; MAX_STUFF_ONES = 6; rx state enum.
- One sub-module, usb_nrzi_unstuff: per-cycle NRZI decode plus stuff-bit removal. Outputs bit, bit_valid and stuff_err; has a clear input used on SYNC/rx_en low.

Test Plan:
- SYNC + ACK PID 0xD2 (NRZI-encoded) + SE0,SE0,J -> pkt_start; byte_valid with byte_data=0xD2, byte_cnt=1; pkt_end; no errors.
- DATA0 0xC3, 0xFF, 0x01 with correct stuff bit after six 1s -> bytes 0xC3, 0xFF, 0x01 delivered; byte_cnt=3; pkt_end.
- Same stream with the stuff bit inverted -> stuff_err pulse, no further byte_valid; IDLE after 2 J; next packet received normally.
- SE0 after 12 data bits -> align_err, no pkt_end; SE0×3 then J on aligned data -> eop_err.
- Corrupted SYNC (K J K K J K J K K ...) -> no pkt_start until a full 8-sample match; 68 bytes with MAX_BYTES=67 -> len_err on the 68th byte.
- rx_en dropped mid-byte, and separately rst_b asserted mid-packet -> outputs 0 immediately on reset, no pulses; a clean packet afterward decodes correctly. With USB_RX_PID_CHECK_EN, PID 0xD3 -> pid_err.
